// File: rtl/hdb3_polar_mc.sv
// hdb3_polar_mc
// Multi-channel HDB3/AMI polarity stage. Each channel receives an already
// substituted 2-bit symbol (00 zero, 01 mark, 10 B pulse, 11 V pulse) and
// turns it into dual-rail bp/bn line pulses, keeping its own alternation
// state. Two register stages: stage 1 holds the polarity decision and the
// error flag, stage 2 holds the line outputs.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   in_valid     qualifies data_plug_b for all channels this cycle
//   data_plug_b  channel i symbol at [2i+1:2i]
//   mode         0 = HDB3, 1 = AMI, sampled on each valid cycle
//   clr_stat     synchronous clear of every pulse counter
//   out_valid    qualifier for bp/bn/viol_err (in_valid delayed two cycles)
//   bp / bn      positive / negative pulse per channel
//   viol_err     one-cycle error flag per channel, aligned with bp/bn
//   pulse_cnt    saturating pulse count, channel i at [CNT_W*(i+1)-1:CNT_W*i]
module hdb3_polar_mc #(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 16,
   parameter int INV_POL = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic [2*NUM_CH-1:0]     data_plug_b,
   input  logic                    mode,
   input  logic                    clr_stat,
   output logic                    out_valid,
   output logic [NUM_CH-1:0]       bp,
   output logic [NUM_CH-1:0]       bn,
   output logic [NUM_CH-1:0]       viol_err,
   output logic [CNT_W*NUM_CH-1:0] pulse_cnt
);

   typedef enum logic [1:0] {
      POL_NONE = 2'b00,
      POL_POS  = 2'b01,
      POL_NEG  = 2'b10
   } pol_t;

   // r_lastPol: 1 = last pulse was positive, 0 = negative
   logic [NUM_CH-1:0] r_lastPol;
   logic [NUM_CH-1:0] r_vPend;
   pol_t              r_s1Pol [NUM_CH];
   logic [NUM_CH-1:0] r_s1Err;
   logic              r_s1Valid;
   logic [CNT_W-1:0]  r_cnt [NUM_CH];
   logic [NUM_CH-1:0] r_bp;
   logic [NUM_CH-1:0] r_bn;
   logic [NUM_CH-1:0] r_viol;
   logic              r_s2Valid;

   pol_t              w_pol [NUM_CH];
   logic [NUM_CH-1:0] w_err;
   logic [NUM_CH-1:0] w_pulse;
   logic [NUM_CH-1:0] w_nextLastPol;
   logic [NUM_CH-1:0] w_nextVPend;

   // Per-channel polarity decision. A mark or B pulse alternates against
   // the last pulse; a V repeats the last polarity, and a second V with no
   // alternating pulse in between is flagged but still sent. In AMI mode
   // only marks are legal, so B/V symbols are dropped and flagged, and the
   // V bookkeeping is kept cleared. Nothing moves on an invalid cycle.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         w_pol[i]         = POL_NONE;
         w_err[i]         = 1'b0;
         w_pulse[i]       = 1'b0;
         w_nextLastPol[i] = r_lastPol[i];
         w_nextVPend[i]   = r_vPend[i];
         if (in_valid) begin
            if (mode) begin
               w_nextVPend[i] = 1'b0;
               case (data_plug_b[2*i +: 2])
                  2'b01: begin
                     w_pol[i]         = r_lastPol[i] ? POL_NEG : POL_POS;
                     w_pulse[i]       = 1'b1;
                     w_nextLastPol[i] = ~r_lastPol[i];
                  end
                  2'b10, 2'b11: w_err[i] = 1'b1;
                  default: ;
               endcase
            end else begin
               case (data_plug_b[2*i +: 2])
                  2'b01, 2'b10: begin
                     w_pol[i]         = r_lastPol[i] ? POL_NEG : POL_POS;
                     w_pulse[i]       = 1'b1;
                     w_nextLastPol[i] = ~r_lastPol[i];
                     w_nextVPend[i]   = 1'b0;
                  end
                  2'b11: begin
                     w_pol[i]       = r_lastPol[i] ? POL_POS : POL_NEG;
                     w_pulse[i]     = 1'b1;
                     w_err[i]       = r_vPend[i];
                     w_nextVPend[i] = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   // Stage 1: alternation state, registered decision and pulse counters.
   // Counters saturate instead of wrapping, and a clear beats an increment
   // arriving in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lastPol <= '0;
         r_vPend   <= '0;
         r_s1Err   <= '0;
         r_s1Valid <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            r_s1Pol[i] <= POL_NONE;
            r_cnt[i]   <= '0;
         end
      end else begin
         if (in_valid) begin
            r_lastPol <= w_nextLastPol;
            r_vPend   <= w_nextVPend;
         end
         r_s1Err   <= w_err;
         r_s1Valid <= in_valid;
         for (int i = 0; i < NUM_CH; i++) begin
            r_s1Pol[i] <= w_pol[i];
            if (clr_stat)
               r_cnt[i] <= '0;
            else if (w_pulse[i] && (r_cnt[i] != {CNT_W{1'b1}}))
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
         end
      end
   end

   // Stage 2: map the polarity code onto the two rails. A code can only be
   // one of pos/neg/none, so both rails are never high together; the
   // INV_POL build simply swaps which rail carries which polarity.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bp      <= '0;
         r_bn      <= '0;
         r_viol    <= '0;
         r_s2Valid <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (INV_POL != 0) begin
               r_bp[i] <= (r_s1Pol[i] == POL_NEG);
               r_bn[i] <= (r_s1Pol[i] == POL_POS);
            end else begin
               r_bp[i] <= (r_s1Pol[i] == POL_POS);
               r_bn[i] <= (r_s1Pol[i] == POL_NEG);
            end
         end
         r_viol    <= r_s1Err;
         r_s2Valid <= r_s1Valid;
      end
   end

   assign out_valid = r_s2Valid;
   assign bp        = r_bp;
   assign bn        = r_bn;
   assign viol_err  = r_viol;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
      assign pulse_cnt[CNT_W*g +: CNT_W] = r_cnt[g];
   end

endmodule

// File: tb/tb_hdb3_polar_mc.sv
// tb_hdb3_polar_mc
// Directed bench for hdb3_polar_mc. The main instance uses 2-bit counters so
// saturation is reachable; a second instance with INV_POL = 1 and 16-bit
// counters shares the same inputs to cover the rail swap and wide counters.
module tb_hdb3_polar_mc;

   localparam int NUM_CH = 4;

   logic clk = 1'b0;
   logic rst;
   logic in_valid;
   logic [2*NUM_CH-1:0] data_plug_b;
   logic mode;
   logic clr_stat;

   logic              outValid;
   logic [NUM_CH-1:0] bp, bn, violErr;
   logic [2*NUM_CH-1:0]  pulseCnt;
   logic              outValidI;
   logic [NUM_CH-1:0] bpI, bnI, violErrI;
   logic [16*NUM_CH-1:0] pulseCntI;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [7:0]        stimSym   [32];
   logic              stimValid [32];
   logic              stimMode  [32];
   logic              stimClr   [32];
   logic              obsOv     [32];
   logic [NUM_CH-1:0] obsBp     [32];
   logic [NUM_CH-1:0] obsBn     [32];
   logic [NUM_CH-1:0] obsErr    [32];
   logic [NUM_CH-1:0] obsBpI    [32];
   logic [NUM_CH-1:0] obsBnI    [32];

   hdb3_polar_mc #(.NUM_CH(NUM_CH), .CNT_W(2), .INV_POL(0)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .data_plug_b(data_plug_b),
      .mode(mode), .clr_stat(clr_stat), .out_valid(outValid), .bp(bp),
      .bn(bn), .viol_err(violErr), .pulse_cnt(pulseCnt)
   );

   hdb3_polar_mc #(.NUM_CH(NUM_CH), .CNT_W(16), .INV_POL(1)) dutInv (
      .clk(clk), .rst(rst), .in_valid(in_valid), .data_plug_b(data_plug_b),
      .mode(mode), .clr_stat(clr_stat), .out_valid(outValidI), .bp(bpI),
      .bn(bnI), .viol_err(violErrI), .pulse_cnt(pulseCntI)
   );

   always #5 clk = ~clk;

   // Symbol bus with one channel carrying a code and the rest zero
   function automatic logic [7:0] symAt(input int ch, input logic [1:0] code);
      logic [7:0] v;
      v = '0;
      v[2*ch +: 2] = code;
      return v;
   endfunction

   // Expected {bp,bn} for a polarity code: 0 none, 1 positive, 2 negative
   function automatic logic [1:0] polBits(input int e);
      return (e == 1) ? 2'b10 : (e == 2) ? 2'b01 : 2'b00;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic doReset;
      rst = 1'b1; in_valid = 1'b0; data_plug_b = '0; mode = 1'b0; clr_stat = 1'b0;
      tick;
      tick;
      rst = 1'b0;
   endtask

   task automatic setStim(input int j, input logic [7:0] s, input logic v,
                          input logic m, input logic c);
      stimSym[j] = s; stimValid[j] = v; stimMode[j] = m; stimClr[j] = c;
   endtask

   // Drives n stimulus entries and records the output belonging to each one
   // (two-cycle latency, so entry k shows up after the edge following k+1).
   task automatic applyStimulus(input int n);
      for (int k = 0; k <= n; k++) begin
         if (k < n) begin
            in_valid = stimValid[k]; data_plug_b = stimSym[k];
            mode = stimMode[k]; clr_stat = stimClr[k];
         end else begin
            in_valid = 1'b0; data_plug_b = '0; clr_stat = 1'b0;
         end
         tick;
         if (k >= 1) begin
            obsOv[k-1] = outValid; obsBp[k-1] = bp; obsBn[k-1] = bn;
            obsErr[k-1] = violErr; obsBpI[k-1] = bpI; obsBnI[k-1] = bnI;
         end
      end
   endtask

   task automatic test_reset;
      doReset;
      testsRun++;
      if (outValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_out_valid: got %b expected 0", outValid); end
      testsRun++;
      if ({bp, bn, violErr} !== '0) begin testsFailed++; $display("[TB] FAIL rst_rails: got %b expected 0", {bp, bn, violErr}); end
      testsRun++;
      if (pulseCnt !== '0) begin testsFailed++; $display("[TB] FAIL rst_cnt: got %h expected 0", pulseCnt); end
      testsRun++;
      if (pulseCntI !== '0) begin testsFailed++; $display("[TB] FAIL rst_cnt_inv: got %h expected 0", pulseCntI); end
   endtask

   task automatic test_mark;
      int e[4] = '{1, 2, 0, 1};
      doReset;
      setStim(0, symAt(0, 2'b01), 1'b1, 1'b0, 1'b0);
      setStim(1, symAt(0, 2'b01), 1'b1, 1'b0, 1'b0);
      setStim(2, symAt(0, 2'b00), 1'b1, 1'b0, 1'b0);
      setStim(3, symAt(0, 2'b01), 1'b1, 1'b0, 1'b0);
      applyStimulus(4);
      for (int j = 0; j < 4; j++) begin
         testsRun++;
         if (obsOv[j] !== 1'b1) begin testsFailed++; $display("[TB] FAIL t1_out_valid[%0d]: got %b expected 1", j, obsOv[j]); end
         testsRun++;
         if ({obsBp[j][0], obsBn[j][0]} !== polBits(e[j])) begin testsFailed++; $display("[TB] FAIL t1_bpbn[%0d]: got %b expected %b", j, {obsBp[j][0], obsBn[j][0]}, polBits(e[j])); end
         testsRun++;
         if ({obsBnI[j][0], obsBpI[j][0]} !== polBits(e[j])) begin testsFailed++; $display("[TB] FAIL t1_inv_bnbp[%0d]: got %b expected %b", j, {obsBnI[j][0], obsBpI[j][0]}, polBits(e[j])); end
      end
      tick;
      testsRun++;
      if (outValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL t1_out_valid_tail: got %b expected 0", outValid); end
      testsRun++;
      if (pulseCnt[1:0] !== 2'd3) begin testsFailed++; $display("[TB] FAIL t1_cnt0: got %0d expected 3", pulseCnt[1:0]); end
      testsRun++;
      if (pulseCntI[15:0] !== 16'd3) begin testsFailed++; $display("[TB] FAIL t1_cnt0_inv: got %0d expected 3", pulseCntI[15:0]); end
   endtask

   task automatic test_hdb3_violation;
      logic [1:0] s[9] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 2'b00, 2'b11};
      int e[9] = '{1, 0, 0, 0, 1, 2, 0, 0, 2};
      doReset;
      for (int j = 0; j < 9; j++) setStim(j, symAt(0, s[j]), 1'b1, 1'b0, 1'b0);
      applyStimulus(9);
      for (int j = 0; j < 9; j++) begin
         testsRun++;
         if ({obsBp[j][0], obsBn[j][0]} !== polBits(e[j])) begin testsFailed++; $display("[TB] FAIL t2_bpbn[%0d]: got %b expected %b", j, {obsBp[j][0], obsBn[j][0]}, polBits(e[j])); end
         testsRun++;
         if (obsErr[j][0] !== 1'b0) begin testsFailed++; $display("[TB] FAIL t2_viol[%0d]: got %b expected 0", j, obsErr[j][0]); end
      end
   endtask

   task automatic test_double_v;
      logic [1:0] s[3] = '{2'b11, 2'b11, 2'b01};
      int e[3] = '{2, 2, 1};
      logic x[3] = '{1'b0, 1'b1, 1'b0};
      doReset;
      for (int j = 0; j < 3; j++) setStim(j, symAt(0, s[j]), 1'b1, 1'b0, 1'b0);
      applyStimulus(3);
      for (int j = 0; j < 3; j++) begin
         testsRun++;
         if ({obsBp[j][0], obsBn[j][0]} !== polBits(e[j])) begin testsFailed++; $display("[TB] FAIL t3_bpbn[%0d]: got %b expected %b", j, {obsBp[j][0], obsBn[j][0]}, polBits(e[j])); end
         testsRun++;
         if (obsErr[j][0] !== x[j]) begin testsFailed++; $display("[TB] FAIL t3_viol[%0d]: got %b expected %b", j, obsErr[j][0], x[j]); end
      end
   endtask

   task automatic test_ami;
      logic [1:0] s[4] = '{2'b01, 2'b10, 2'b11, 2'b01};
      int e[4] = '{1, 0, 0, 2};
      logic x[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      doReset;
      for (int j = 0; j < 4; j++) setStim(j, symAt(1, s[j]), 1'b1, 1'b1, 1'b0);
      applyStimulus(4);
      for (int j = 0; j < 4; j++) begin
         testsRun++;
         if ({obsBp[j][1], obsBn[j][1]} !== polBits(e[j])) begin testsFailed++; $display("[TB] FAIL t4_bpbn[%0d]: got %b expected %b", j, {obsBp[j][1], obsBn[j][1]}, polBits(e[j])); end
         testsRun++;
         if (obsErr[j][1] !== x[j]) begin testsFailed++; $display("[TB] FAIL t4_viol[%0d]: got %b expected %b", j, obsErr[j][1], x[j]); end
         testsRun++;
         if ({obsBp[j][0], obsBn[j][0], obsErr[j][0]} !== 3'b000) begin testsFailed++; $display("[TB] FAIL t4_ch0_quiet[%0d]: got %b expected 000", j, {obsBp[j][0], obsBn[j][0], obsErr[j][0]}); end
      end
      testsRun++;
      if (pulseCnt[3:2] !== 2'd2) begin testsFailed++; $display("[TB] FAIL t4_cnt1: got %0d expected 2", pulseCnt[3:2]); end
   endtask

   task automatic test_valid_gap;
      logic v[3] = '{1'b1, 1'b0, 1'b1};
      int e[3] = '{1, 0, 2};
      doReset;
      for (int j = 0; j < 3; j++) setStim(j, symAt(0, 2'b01), v[j], 1'b0, 1'b0);
      applyStimulus(3);
      for (int j = 0; j < 3; j++) begin
         testsRun++;
         if (obsOv[j] !== v[j]) begin testsFailed++; $display("[TB] FAIL t5_out_valid[%0d]: got %b expected %b", j, obsOv[j], v[j]); end
         testsRun++;
         if ({obsBp[j][0], obsBn[j][0]} !== polBits(e[j])) begin testsFailed++; $display("[TB] FAIL t5_bpbn[%0d]: got %b expected %b", j, {obsBp[j][0], obsBn[j][0]}, polBits(e[j])); end
      end
   endtask

   task automatic test_back_to_back;
      doReset;
      for (int j = 0; j < 5; j++) setStim(j, symAt(2, 2'b01), 1'b1, 1'b0, 1'b0);
      applyStimulus(5);
      testsRun++;
      if (pulseCnt[5:4] !== 2'd3) begin testsFailed++; $display("[TB] FAIL t6_cnt_sat: got %0d expected 3", pulseCnt[5:4]); end
      testsRun++;
      if (pulseCntI[47:32] !== 16'd5) begin testsFailed++; $display("[TB] FAIL t6_cnt_wide: got %0d expected 5", pulseCntI[47:32]); end
      // Sixth mark, sent together with the clear: pulse goes out, count drops
      setStim(0, symAt(2, 2'b01), 1'b1, 1'b0, 1'b1);
      applyStimulus(1);
      testsRun++;
      if ({obsBp[0][2], obsBn[0][2]} !== 2'b01) begin testsFailed++; $display("[TB] FAIL t6_clr_pulse: got %b expected 01", {obsBp[0][2], obsBn[0][2]}); end
      testsRun++;
      if (pulseCnt[5:4] !== 2'd0) begin testsFailed++; $display("[TB] FAIL t6_clr_cnt: got %0d expected 0", pulseCnt[5:4]); end
      // Seventh mark (positive) enters stage 1, then reset lands mid-stream
      in_valid = 1'b1; data_plug_b = symAt(2, 2'b01);
      tick;
      rst = 1'b1;
      tick;
      testsRun++;
      if ({outValid, bp, bn, violErr} !== '0) begin testsFailed++; $display("[TB] FAIL t6_rst_flush: got %b expected 0", {outValid, bp, bn, violErr}); end
      testsRun++;
      if (pulseCnt !== '0) begin testsFailed++; $display("[TB] FAIL t6_rst_cnt: got %h expected 0", pulseCnt); end
      rst = 1'b0;
      tick;
      in_valid = 1'b0; data_plug_b = '0;
      tick;
      testsRun++;
      if ({outValid, bp[2], bn[2]} !== 3'b110) begin testsFailed++; $display("[TB] FAIL t6_post_rst_pos: got %b expected 110", {outValid, bp[2], bn[2]}); end
      testsRun++;
      if (pulseCnt[5:4] !== 2'd1) begin testsFailed++; $display("[TB] FAIL t6_post_rst_cnt: got %0d expected 1", pulseCnt[5:4]); end
   endtask

   initial begin
      test_reset;
      test_mark;
      test_hdb3_violation;
      test_double_v;
      test_ami;
      test_valid_gap;
      test_back_to_back;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
